// File: rtl/imem_loader.sv
// Byte-stream program loader: frames SYNC_BYTE, 16-bit word count, little-endian words,
// writes them to instruction memory and holds the core in reset until the image is complete.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          LENGTH    = 1024,
  parameter int          WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'h55
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Byte handshake: a byte transfers on a rising edge where rx_valid && rx_ready;
  // the source must hold rx_data stable while rx_valid is high and rx_ready is low.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CHK   = 3'd6
`endif
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'(LENGTH);

  state_t           state_q;
  state_t           state_d;
  state_t           fin_state;
  logic [1:0]       byte_idx_q;
  logic [15:0]      word_cnt_q;
  logic [15:0]      n_words_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             accept;
  logic             is_sync;
  logic [15:0]      len_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q;
`endif

  assign rx_ready = (state_q != S_WRITE);
  assign accept   = rx_valid && rx_ready;
  assign is_sync  = accept && (rx_data == SYNC_BYTE);
  // Count as it will look once the high byte in flight is captured.
  assign len_word = {rx_data, n_words_q[7:0]};

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign fin_state = S_CHK;
`else
  assign fin_state = S_DONE;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (is_sync) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept && byte_idx_q[0]) begin
          if ({1'b0, len_word} > LEN_MAX) state_d = S_ERROR;
          else if (len_word == 16'd0)     state_d = fin_state;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if ((word_cnt_q + 16'd1) == n_words_q) state_d = fin_state;
        else                                   state_d = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: byte index, word assembly, address and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      word_cnt_q <= 16'd0;
      n_words_q  <= 16'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (is_sync) begin
            byte_idx_q <= 2'd0;
            word_cnt_q <= 16'd0;
            addr_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
          end
        end
        S_LEN: begin
          if (accept) begin
            if (byte_idx_q[0]) n_words_q[15:8] <= rx_data;
            else               n_words_q[7:0]  <= rx_data;
            // Two length bytes: index toggles 0 -> 1 -> 0 so DATA starts at byte 0.
            byte_idx_q <= {1'b0, ~byte_idx_q[0]};
          end
        end
        S_DATA: begin
          if (accept) begin
            wdata_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ rx_data;
`endif
          end
        end
        S_WRITE: begin
          addr_q     <= addr_q + WIDTH'(4);
          word_cnt_q <= word_cnt_q + 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy      = (state_q == S_LEN) || (state_q == S_DATA) ||
                     (state_q == S_WRITE) || (state_q == S_CHK);
`else
  assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
`endif
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign cpu_rst_n = !(busy || error);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized images checked against a queue-based
// model of the framing rules (write list, word count bound, checksum when enabled).
module tb_imem_loader;

  localparam int         LENGTH = 1024;
  localparam int         WIDTH  = 32;
  localparam logic [7:0] SYNC   = 8'h55;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             cpu_rst_n;
  logic             busy;
  logic             done;
  logic             error;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] img_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int we_cnt;
  int not_ready_cnt;
  int incoherent_cnt;

  imem_loader #(.LENGTH(LENGTH), .WIDTH(WIDTH), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor: observes the memory port away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        got_q.push_back({mem_addr, mem_wdata});
        we_cnt++;
      end
      if (!rx_ready) not_ready_cnt++;
      if (mem_we == rx_ready) incoherent_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic build_expected();
    exp_q.delete();
    foreach (img_q[i]) exp_q.push_back({32'(i * 4), img_q[i]});
  endtask

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    foreach (img_q[i]) c = c ^ img_q[i][7:0] ^ img_q[i][15:8] ^ img_q[i][23:16] ^ img_q[i][31:24];
    return c;
  endfunction

  task automatic clear_monitor();
    got_q.delete();
    we_cnt = 0;
    not_ready_cnt = 0;
    incoherent_cnt = 0;
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int t;
    logic ok;
    rx_data = b;
    rx_valid = 1'b1;
    t = 0;
    do begin
      ok = rx_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!ok && t < 50);
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_byte: byte %02h not accepted, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic idle_bus();
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_image(input bit gaps);
    int n;
    n = img_q.size();
    send_byte(SYNC);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (img_q[i]) begin
      for (int k = 0; k < 4; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) idle_bus();
        send_byte(img_q[i][8*k +: 8]);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_csum());
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(done || error)) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_end: load did not finish, done=%b error=%b", done, error);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    clear_monitor();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error, rx_ready} !==
        {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_values: we=%b addr=%h wdata=%h cpu_rst_n=%b busy=%b done=%b error=%b rdy=%b",
               mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error, rx_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle_bus();
    idle_bus();
    n_checks++;
    if (we_cnt !== 0) begin
      n_errors++; $display("FAIL idle_no_write: writes=%0d required 0", we_cnt);
    end
    n_checks++;
    if ({cpu_rst_n, busy, done, error} !== 4'b1000) begin
      n_errors++;
      $display("FAIL idle_flags: cpu_rst_n=%b busy=%b done=%b error=%b required 1 0 0 0",
               cpu_rst_n, busy, done, error);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] seq[11];
    seq = '{8'h55, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_monitor();
    img_q = '{32'h0000_0013, 32'h0010_0093};
    build_expected();
    for (int i = 0; i < 11; i++) begin
      send_byte(seq[i]);
      if (i == 6 || i == 10) begin
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_q[i / 7]}) begin
          n_errors++;
          $display("FAIL two_words_write%0d: we=%b addr=%h data=%h required 1 %h",
                   i / 7, mem_we, mem_addr, mem_wdata, exp_q[i / 7]);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_csum());
    rx_valid = 1'b0;
`else
    idle_bus();
`endif
    n_checks++;
    if ({done, error, cpu_rst_n, busy} !== 4'b1010) begin
      n_errors++;
      $display("FAIL two_words_done: done=%b error=%b cpu_rst_n=%b busy=%b required 1 0 1 0",
               done, error, cpu_rst_n, busy);
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL two_words_count: writes=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL two_words_data%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_oversize();
    int n;
    clear_monitor();
    n = LENGTH + 1;
    send_byte(SYNC);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    idle_bus();
    n_checks++;
    if ({error, done, cpu_rst_n, busy} !== 4'b1000 || we_cnt !== 0) begin
      n_errors++;
      $display("FAIL oversize: error=%b done=%b cpu_rst_n=%b busy=%b writes=%0d required 1 0 0 0 0",
               error, done, cpu_rst_n, busy, we_cnt);
    end
    send_byte(8'h13);
    n_checks++;
    if (error !== 1'b1) begin
      n_errors++; $display("FAIL error_sticky: error=%b required 1", error);
    end
    send_byte(SYNC);
    n_checks++;
    if ({error, busy, cpu_rst_n} !== 3'b010) begin
      n_errors++;
      $display("FAIL error_clear: error=%b busy=%b cpu_rst_n=%b required 0 1 0", error, busy, cpu_rst_n);
    end
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle_bus();
    n_checks++;
    if ({done, error, we_cnt != 0} !== 3'b100) begin
      n_errors++; $display("FAIL zero_len: done=%b error=%b writes=%0d required 1 0 0", done, error, we_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int iter = 0; iter < 4; iter++) begin
      int n;
      clear_monitor();
      img_q.delete();
      n = (iter == 3) ? LENGTH : $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        // bias towards SYNC bytes inside data
        img_q.push_back(($urandom_range(0, 4) == 0) ? 32'h5555_5555 : $urandom);
      end
      build_expected();
      load_image(iter == 1 || iter == 2);
      wait_end();
      idle_bus();
      n_checks++;
      if ({done, error, cpu_rst_n} !== 3'b101) begin
        n_errors++;
        $display("FAIL b2b%0d_done: done=%b error=%b cpu_rst_n=%b required 1 0 1", iter, done, error, cpu_rst_n);
      end
      n_checks++;
      if (we_cnt !== n || not_ready_cnt !== n || incoherent_cnt !== 0) begin
        n_errors++;
        $display("FAIL b2b%0d_ready: writes=%0d notready=%0d incoherent=%0d required %0d %0d 0",
                 iter, we_cnt, not_ready_cnt, incoherent_cnt, n, n);
      end
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
        n_errors++; $display("FAIL b2b%0d_count: writes=%0d required %0d", iter, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL b2b%0d_word%0d: got %h required %h", iter, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_monitor();
    img_q.delete();
    for (int i = 0; i < 4; i++) img_q.push_back($urandom);
    send_byte(SYNC);
    send_byte(8'h04);
    send_byte(8'h00);
    for (int i = 0; i < 9; i++) send_byte(img_q[i / 4][8*(i % 4) +: 8]);
    rx_valid = 1'b0;
    n_checks++;
    if (we_cnt !== 2) begin
      n_errors++; $display("FAIL mid_writes: writes=%0d required 2", we_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error} !==
        {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset: we=%b addr=%h wdata=%h cpu_rst_n=%b busy=%b done=%b error=%b",
               mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_monitor();
    img_q = '{$urandom};
    build_expected();
    load_image(1'b0);
    wait_end();
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0] || done !== 1'b1) begin
      n_errors++;
      $display("FAIL reload_after_reset: writes=%0d first=%h done=%b required 1 %h 1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'h0, done, exp_q[0]);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] seq[8];
      seq = '{8'h55, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      if (pass == 1) seq[7] = 8'h12;
      clear_monitor();
      img_q = '{32'h0000_0013};
      build_expected();
      for (int i = 0; i < 8; i++) send_byte(seq[i]);
      rx_valid = 1'b0;
      n_checks++;
      if ({done, error, cpu_rst_n} !== ((pass == 0) ? 3'b101 : 3'b010)) begin
        n_errors++;
        $display("FAIL csum%0d_status: done=%b error=%b cpu_rst_n=%b", pass, done, error, cpu_rst_n);
      end
      n_checks++;
      if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
        n_errors++;
        $display("FAIL csum%0d_write: writes=%0d required 1 of %h", pass, got_q.size(), exp_q[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_oversize();
    test_back_to_back();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
